// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and widths for the mux scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    // Channel index width (4 channels) and dwell counter width (DWELL <= 15).
    localparam int CH_W  = 2;
    localparam int CNT_W = 4;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker. Returns the first set
//               request bit searching upward from last+1, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_scan_pkg::*;
(
    input  logic [3:0]      req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] grant,
    output logic            any
);

    logic w_found;

    // Walk last+1, last+2, last+3, last+4 (== last) and keep the first hit.
    always_comb begin
        grant   = last;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_found && req[CH_W'(last + CH_W'(i))]) begin
                grant   = CH_W'(last + CH_W'(i));
                w_found = 1'b1;
            end
        end
    end

    // Any request present at all.
    always_comb begin
        any = |req;
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Round-robin scan controller for a downstream tri-state 4:1
//               mux. Holds each granted channel for DWELL cycles (1..15),
//               with one SEEK gap cycle between channels.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic       done,
    output logic       busy
);

    // Dwell counter counts down from DWELL-1 to 0.
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(DWELL - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_sel;
    logic [CH_W-1:0]   w_sel_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CH_W-1:0]   r_last;
    logic [CH_W-1:0]   w_last_nxt;
    logic [CH_W-1:0]   w_grant;
    logic              w_any;
    logic              w_sel_req;

    rr_pick4 u_rr_pick4 (
        .req   (req),
        .last  (r_last),
        .grant (w_grant),
        .any   (w_any)
    );

    assign w_sel_req = req[r_sel];

    // State, selection, counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_last  <= CH_W'(3);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic: seek a grant, dwell on it, abort if its request drops.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_nxt = SEEK;
                end
            end
            SEEK: begin
                if (en && w_any) begin
                    w_sel_nxt   = w_grant;
                    w_cnt_nxt   = C_CNT_LOAD;
                    w_state_nxt = mux_scan_pkg::DWELL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            mux_scan_pkg::DWELL: begin
                if (!w_sel_req) begin
                    // Requester withdrew: move on without a done pulse.
                    w_last_nxt  = r_sel;
                    w_state_nxt = SEEK;
                end else if (r_cnt == '0) begin
                    // Dwell complete; en only matters once the dwell ends.
                    w_last_nxt  = r_sel;
                    w_state_nxt = en ? SEEK : IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: selects/valid/busy from registers, done also qualified by req.
    always_comb begin
        s0    = r_sel[0];
        s1    = r_sel[1];
        valid = (r_state == mux_scan_pkg::DWELL);
        busy  = (r_state != IDLE);
        done  = (r_state == mux_scan_pkg::DWELL) && (r_cnt == '0) && w_sel_req;
    end

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench. Two controllers (DWELL=4 and DWELL=1)
//               share stimulus; each is compared every cycle against a
//               behavioural scan model, plus directed grant-order checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'd0;

    logic       s0_a, s1_a, valid_a, done_a, busy_a;
    logic       s0_b, s1_b, valid_b, done_b, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: phase 0=idle 1=seek 2=dwell.
    int m_phase   [2];
    int m_ch      [2];
    int m_elapsed [2];
    int m_last    [2];
    int m_dwell   [2] = '{4, 1};

    // Grant capture (first channel of each dwell burst).
    bit cap_en    [2];
    int grants_a  [$];
    int grants_b  [$];
    bit prev_v    [2];

    mux_scan_ctrl #(.DWELL(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .s0(s0_a), .s1(s1_a), .valid(valid_a), .done(done_a), .busy(busy_a)
    );

    mux_scan_ctrl #(.DWELL(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .s0(s0_b), .s1(s1_b), .valid(valid_b), .done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Advance one model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int i);
        if (rst) begin
            m_phase[i] = 0; m_ch[i] = 0; m_elapsed[i] = 0; m_last[i] = 3;
        end else if (m_phase[i] == 0) begin
            if (en && req != 0) m_phase[i] = 1;
        end else if (m_phase[i] == 1) begin
            if (en && req != 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (req[(m_last[i] + k) % 4]) begin
                        m_ch[i] = (m_last[i] + k) % 4;
                        break;
                    end
                end
                m_elapsed[i] = 0;
                m_phase[i]   = 2;
            end else begin
                m_phase[i] = 0;
            end
        end else begin
            if (!req[m_ch[i]]) begin
                m_last[i]  = m_ch[i];
                m_phase[i] = 1;
            end else if (m_elapsed[i] == m_dwell[i] - 1) begin
                m_last[i]  = m_ch[i];
                m_phase[i] = en ? 1 : 0;
            end else begin
                m_elapsed[i]++;
            end
        end
    endtask

    task automatic check_outputs(input int i, input logic v, input logic d,
                                 input logic b, input logic s1x, input logic s0x);
        string p;
        p = (i == 0) ? "a" : "b";
        chk({p, "_valid"}, int'(v), int'(m_phase[i] == 2));
        chk({p, "_busy"},  int'(b), int'(m_phase[i] != 0));
        chk({p, "_done"},  int'(d), int'(m_phase[i] == 2 && m_elapsed[i] == m_dwell[i] - 1
                                        && req[m_ch[i]]));
        chk({p, "_sel"},   int'({s1x, s0x}), m_ch[i]);
    endtask

    // One bench cycle: drive at negedge, check shortly after, step models at posedge.
    task automatic cycle(input logic r, input logic e, input logic [3:0] q);
        @(negedge clk);
        rst = r; en = e; req = q;
        #1;
        check_outputs(0, valid_a, done_a, busy_a, s1_a, s0_a);
        check_outputs(1, valid_b, done_b, busy_b, s1_b, s0_b);
        if (cap_en[0] && valid_a && !prev_v[0]) grants_a.push_back(int'({s1_a, s0_a}));
        if (cap_en[1] && valid_b && !prev_v[1]) grants_b.push_back(int'({s1_b, s0_b}));
        prev_v[0] = valid_a;
        prev_v[1] = valid_b;
        @(posedge clk);
        model_step(0);
        model_step(1);
    endtask

    initial begin
        int exp_a [5] = '{0, 1, 2, 3, 0};
        int exp_b [4] = '{1, 3, 1, 3};
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_ch[i] = 0; m_elapsed[i] = 0; m_last[i] = 3;
            cap_en[i] = 1'b0; prev_v[i] = 1'b0;
        end

        // Reset, then full request set: order 0,1,2,3,0 on the DWELL=4 unit.
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b1, 1'b1, 4'b1111);
        cap_en[0] = 1'b1;
        for (int c = 0; c < 28; c++) cycle(1'b0, 1'b1, 4'b1111);
        cap_en[0] = 1'b0;
        chk("order_len_a", grants_a.size() >= 5 ? 5 : grants_a.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("order_a%0d", k), (k < grants_a.size()) ? grants_a[k] : -1, exp_a[k]);

        // Single requester on channel 2.
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b1, 4'b0100);

        // Abort: drop req[1] on the 2nd dwell cycle of ch1 (unit a).
        cycle(1'b1, 1'b0, 4'b0000);
        for (int c = 0; c < 60; c++) begin
            if (m_phase[0] == 2 && m_ch[0] == 1 && m_elapsed[0] == 1) begin
                cycle(1'b0, 1'b1, 4'b0001);
                break;
            end
            cycle(1'b0, 1'b1, 4'b0011);
        end
        for (int c = 0; c < 8; c++) cycle(1'b0, 1'b1, 4'b0011);

        // en dropped on the first dwell cycle: dwell completes, then idle.
        for (int c = 0; c < 60; c++) begin
            if (m_phase[0] == 2 && m_elapsed[0] == 0) break;
            cycle(1'b0, 1'b1, 4'b1111);
        end
        for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, 4'b1111);
        chk("idle_after_en_drop", int'(busy_a), 0);

        // Reset mid-dwell on ch2, then first grant is ch0.
        for (int c = 0; c < 60; c++) begin
            if (m_phase[0] == 2 && m_ch[0] == 2 && m_elapsed[0] == 1) break;
            cycle(1'b0, 1'b1, 4'b1111);
        end
        cycle(1'b1, 1'b1, 4'b1111);
        #1;
        chk("rst_mid_valid", int'(valid_a), 0);
        chk("rst_mid_busy",  int'(busy_a), 0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 4'b1111);
        chk("rst_first_grant", int'({s1_a, s0_a}), 0);

        // DWELL=1 unit with req=1010: grants 1,3,1,3.
        cycle(1'b1, 1'b0, 4'b0000);
        cap_en[1] = 1'b1;
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1, 4'b1010);
        cap_en[1] = 1'b0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("order_b%0d", k), (k < grants_b.size()) ? grants_b[k] : -1, exp_b[k]);

        // Randomized traffic, model-checked every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic       r, e;
            logic [3:0] q;
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 99) < 85);
            q = ($urandom_range(0, 9) < 7) ? req : 4'($urandom);
            cycle(r, e, q);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
